// File: rtl/three_way_toom_cook_seq_pkg.sv
// Shared types and size helpers for the three-way carry-less multiplier.
package ttc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2
  } state_t;

  function automatic int limb_w(input int width);
    return width / 3;
  endfunction

  function automatic int steps(input int width, input int digit);
    return width / 3 / digit;
  endfunction

endpackage

// File: rtl/three_way_toom_cook_seq_if.sv
// Start/done request bus of the three-way carry-less multiplier.
interface three_way_toom_cook_seq_if #(parameter int WIDTH = 192);
  // start is accepted on a rising edge where ready=1 (a/b captured then);
  // done pulses for one cycle, c is valid from that cycle until the next result.
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   c;

  modport master (output start, a, b, input ready, done, c);
  modport slave  (input start, a, b, output ready, done, c);
endinterface

// File: rtl/three_way_toom_cook_seq_clmul.sv
// Digit-serial carry-less limb multiplier: DIGIT bits of a_l consumed per step.
module clmul_digit_serial #(
  parameter int L     = 64,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [L-1:0]   a_l_i,
  input  logic [L-1:0]   b_l_i,
  output logic [2*L-2:0] acc_o
`ifdef TTC_ZERO_SKIP_EN
  , output logic         a_zero_o
`endif
);

  logic [L-1:0]   a_q, a_d;
  logic [2*L-2:0] b_q, b_d;
  logic [2*L-2:0] acc_q, acc_d;
  logic [2*L-2:0] pp;

  // b_q is pre-shifted by k*DIGIT, so the digit product never exceeds 2L-1 bits.
  always_comb begin
    pp = '0;
    for (int t = 0; t < DIGIT; t++) begin
      if (a_q[t]) pp = pp ^ (b_q << t);
    end
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (load_i) begin
      a_d   = a_l_i;
      b_d   = {{(L-1){1'b0}}, b_l_i};
      acc_d = '0;
    end else if (step_i) begin
      acc_d = acc_q ^ pp;
      a_d   = a_q >> DIGIT;
      b_d   = b_q << DIGIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
`ifdef TTC_ZERO_SKIP_EN
  assign a_zero_o = ((a_q >> DIGIT) == '0);
`endif

endmodule

// File: rtl/three_way_toom_cook_seq.sv
// Three-way split, digit-serial GF(2)[x] multiplier with start/done handshake.
// Optional early exit on exhausted a-limbs when TTC_ZERO_SKIP_EN is defined.
module three_way_toom_cook_seq
  import ttc_pkg::*;
#(
  parameter int WIDTH = 192,
  parameter int DIGIT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  three_way_toom_cook_seq_if.slave   bus,
  output state_t                     state_o
);

  localparam int L     = limb_w(WIDTH);
  localparam int S     = steps(WIDTH, DIGIT);
  localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
  localparam int CW    = 2 * WIDTH;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q;
  logic [CW-1:0]      c_q, c_d;
  logic               load, step, last;
  logic [2*L-2:0]     p [9];

`ifdef TTC_ZERO_SKIP_EN
  logic [8:0] a_zero;
`endif

  for (genvar gi = 0; gi < 3; gi++) begin : g_a
    for (genvar gj = 0; gj < 3; gj++) begin : g_b
      clmul_digit_serial #(.L(L), .DIGIT(DIGIT)) u_pp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .a_l_i    (bus.a[gi*L +: L]),
        .b_l_i    (bus.b[gj*L +: L]),
        .acc_o    (p[gi*3+gj])
`ifdef TTC_ZERO_SKIP_EN
        , .a_zero_o (a_zero[gi*3+gj])
`endif
      );
    end
  end

`ifdef TTC_ZERO_SKIP_EN
  assign last = (cnt_q == CNT_W'(S-1)) || (&a_zero);
`else
  assign last = (cnt_q == CNT_W'(S-1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        step    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (last) state_d = COMB;
      end
      COMB:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Limb product p_ij lands at weight (i+j)*L; overlaps combine by XOR only.
  always_comb begin
    c_d = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        c_d = c_d ^ (CW'(p[i*3+j]) << ((i + j) * L));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      c_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (state_q == COMB);
      if (state_q == COMB) c_q <= c_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = done_q;
  assign bus.c     = c_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_three_way_toom_cook_seq.sv
// Bench for three_way_toom_cook_seq: directed handshake cases plus random vectors vs a shift-and-XOR model.
module tb_three_way_toom_cook_seq;
  import ttc_pkg::*;

  localparam int W       = 192;
  localparam int D       = 1;
  localparam int L       = W / 3;
  localparam int S       = L / D;
  localparam int TIMEOUT = S + 20;
  localparam int N_RAND  = 600;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_tests;
  int     n_fail;
  logic [2*W-1:0] exp_q[$];

  three_way_toom_cook_seq_if #(.WIDTH(W)) bus ();

  three_way_toom_cook_seq #(.WIDTH(W), .DIGIT(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: schoolbook shift-and-XOR over the full operands
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) r = r ^ ({{W{1'b0}}, y} << i);
    end
    return r;
  endfunction

  // edges from the accepting edge to the edge after which done is high
  function automatic int exp_lat(input logic [W-1:0] x);
`ifdef TTC_ZERO_SKIP_EN
    int m;
    int n;
    m = -1;
    for (int i = 0; i < W; i++) begin
      if (x[i] && ((i % L) > m)) m = i % L;
    end
    n = (m + 1 + D - 1) / D;
    if (n < 1) n = 1;
    return n + 1;
`else
    if (x === 'x) return 0;
    return S + 1;
`endif
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // driver: call at posedge+1 with ready=1; returns in the done cycle
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output logic [2*W-1:0] cv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = rand_w();
    bus.b     = rand_w();
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < TIMEOUT);
    cv = bus.c;
  endtask

  task automatic test_reset();
    int bad;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.c !== '0) begin n_fail++; $display("FAIL reset_c: got %h want 0", bus.c); end
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_tests++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_release_idle: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_directed();
    logic [W-1:0]   one;
    logic [W-1:0]   av [4];
    logic [W-1:0]   bv [4];
    logic [2*W-1:0] want [4];
    logic [2*W-1:0] cv, held;
    int lat;
    one = 1;
    av[0] = one;         bv[0] = one;         want[0] = 1;
    av[1] = one << 191;  bv[1] = one << 191;  want[1] = {{W{1'b0}}, one} << 382;
    av[2] = one << 64;   bv[2] = one << 128;  want[2] = {{W{1'b0}}, one} << 192;
    av[3] = '1;          bv[3] = '1;          want[3] = '0;
    for (int i = 0; i < W; i++) want[3][2*i] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_q.push_back(want[t]);
      run_op(av[t], bv[t], lat, cv);
      n_tests++;
      if (lat != exp_lat(av[t])) begin
        n_fail++; $display("FAIL directed%0d_latency: got %0d want %0d", t, lat, exp_lat(av[t]));
      end
      held = exp_q.pop_front();
      n_tests++;
      if (cv !== held) begin n_fail++; $display("FAIL directed%0d_c: got %h want %h", t, cv, held); end
      @(posedge clk); #1;
      n_tests++;
      if (bus.done !== 1'b0 || bus.c !== held) begin
        n_fail++; $display("FAIL directed%0d_oneshot_hold: got done=%b c=%h want done=0 c=%h", t, bus.done, bus.c, held);
      end
    end
  endtask

  task automatic test_zero_latency();
    logic [W-1:0]   one, bv, av [3];
    logic [2*W-1:0] cv, want;
    int lat;
    one = 1;
    av[0] = one;
    av[1] = one << 63;
    av[2] = '0;
    for (int t = 0; t < 3; t++) begin
      bv   = rand_w();
      want = ref_mul(av[t], bv);
      run_op(av[t], bv, lat, cv);
      n_tests++;
      if (lat != exp_lat(av[t])) begin
        n_fail++; $display("FAIL zero%0d_latency: got %0d want %0d", t, lat, exp_lat(av[t]));
      end
      n_tests++;
      if (cv !== want) begin n_fail++; $display("FAIL zero%0d_c: got %h want %h", t, cv, want); end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] av, bv;
    logic [2*W-1:0] want;
    int k, lat, extra;
    av = rand_w(); av[L-1] = 1'b1;
    bv = rand_w();
    exp_q.push_back(ref_mul(av, bv));
    k = (S >= 10) ? 10 : S;
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (k - 1) begin @(posedge clk); #1; end
    n_tests++;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_ready: got %b want 0", bus.ready); end
    bus.start = 1'b1; bus.a = rand_w(); bus.b = rand_w();
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = k;
    while (!bus.done && lat < TIMEOUT) begin @(posedge clk); #1; lat++; end
    n_tests++;
    if (lat != exp_lat(av)) begin n_fail++; $display("FAIL ignore_latency: got %0d want %0d", lat, exp_lat(av)); end
    want = exp_q.pop_front();
    n_tests++;
    if (bus.c !== want) begin n_fail++; $display("FAIL ignore_c: got %h want %h", bus.c, want); end
    extra = 0;
    repeat (S + 4) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) extra++;
    end
    n_tests++;
    if (extra != 0 || bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL ignore_single_done: got %0d extra dones ready=%b want 0 and 1", extra, bus.ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [2*W-1:0] c1, c2, want;
    int lat1, lat2;
    a1 = rand_w(); b1 = rand_w();
    a2 = rand_w(); b2 = rand_w();
    exp_q.push_back(ref_mul(a1, b1));
    exp_q.push_back(ref_mul(a2, b2));
    run_op(a1, b1, lat1, c1);
    n_tests++;
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_on_done: got %b want 1", bus.ready); end
    run_op(a2, b2, lat2, c2);
    want = exp_q.pop_front();
    n_tests++;
    if (c1 !== want) begin n_fail++; $display("FAIL b2b_first_c: got %h want %h", c1, want); end
    want = exp_q.pop_front();
    n_tests++;
    if (c2 !== want) begin n_fail++; $display("FAIL b2b_second_c: got %h want %h", c2, want); end
    n_tests++;
    if (lat2 != exp_lat(a2)) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want %0d", lat2, exp_lat(a2)); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] av;
    logic [2*W-1:0] cv;
    int k, lat, extra;
    av = rand_w(); av[L-1] = 1'b1;
    k = (S >= 20) ? 20 : S;
    bus.start = 1'b1; bus.a = av; bus.b = rand_w();
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (k - 1) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.c !== '0 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_clear: got c=%h done=%b ready=%b want 0 0 1", bus.c, bus.done, bus.ready);
    end
    @(negedge clk) rst_n = 1'b1;
    extra = 0;
    repeat (S + 4) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) extra++;
    end
    n_tests++;
    if (extra != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d dones want 0", extra); end
    run_op(3, 3, lat, cv);
    n_tests++;
    if (cv !== 5) begin n_fail++; $display("FAIL midreset_next_c: got %h want 5", cv); end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv;
    logic [2*W-1:0] cv, want;
    int lat, m;
    for (int n = 0; n < N_RAND; n++) begin
      av = rand_w();
      bv = rand_w();
      if ($urandom_range(0, 3) == 0) begin
        m = $urandom_range(0, L - 1);
        for (int i = 0; i < W; i++) if ((i % L) > m) av[i] = 1'b0;
      end
      exp_q.push_back(ref_mul(av, bv));
      run_op(av, bv, lat, cv);
      want = exp_q.pop_front();
      n_tests++;
      if (cv !== want) begin n_fail++; $display("FAIL random%0d_c: got %h want %h", n, cv, want); end
      n_tests++;
      if (lat != exp_lat(av)) begin n_fail++; $display("FAIL random%0d_latency: got %0d want %0d", n, lat, exp_lat(av)); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_zero_latency();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
